// File: rtl/msrv32_pipe_ctrl.sv
// Pipeline sequencer for the msrv32 stage-2/3 register and PC register.
// Resolves redirects, data-memory waits with timeout, load-use hazards and fetch waits.
module msrv32_pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             imem_ready_in,
  input  logic             dmem_req_in,
  input  logic             dmem_ready_in,
  input  logic             ex_load_in,
  input  logic             ex_rf_wr_en_in,
  input  logic [4:0]       ex_rd_addr_in,
  input  logic [4:0]       id_rs1_addr_in,
  input  logic [4:0]       id_rs2_addr_in,
  input  logic             id_rs1_used_in,
  input  logic             id_rs2_used_in,
  input  logic             branch_taken_in,
  input  logic             trap_taken_in,
  output logic             pc_en_out,
  output logic             reg2_en_out,
  output logic             reg2_flush_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic             bus_err_out
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic redirect;
  logic mem_stall;
  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic pc_en;
  logic reg2_en;
  logic flush;

  assign redirect  = branch_taken_in | trap_taken_in;
  assign mem_stall = dmem_req_in & ~dmem_ready_in;
  assign rs1_hit   = id_rs1_used_in & (id_rs1_addr_in == ex_rd_addr_in);
  assign rs2_hit   = id_rs2_used_in & (id_rs2_addr_in == ex_rd_addr_in);
  assign hazard    = ex_load_in & ex_rf_wr_en_in & (ex_rd_addr_in != 5'd0) & (rs1_hit | rs2_hit);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // The stall counter defaults to zero so it reads 0 in every state but WAIT_MEM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    bus_err_d = 1'b0;
    pc_en     = 1'b0;
    reg2_en   = 1'b0;
    flush     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_en   = 1'b1;
          reg2_en = 1'b1;
          flush   = 1'b1;
          state_d = ST_FLUSH;
        end else if (mem_stall) begin
          cnt_d   = CntOne;
          state_d = ST_WAIT_MEM;
        end else if (hazard || !imem_ready_in) begin
          reg2_en = 1'b1;
          flush   = 1'b1;
        end else begin
          pc_en   = 1'b1;
          reg2_en = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        if (dmem_ready_in && redirect) begin
          pc_en   = 1'b1;
          reg2_en = 1'b1;
          flush   = 1'b1;
          state_d = ST_FLUSH;
        end else if (dmem_ready_in) begin
          pc_en   = 1'b1;
          reg2_en = 1'b1;
          state_d = ST_RUN;
        end else if (cnt_q == CntLast) begin
          // Abandon the access: bubble out the stuck instruction and flag it.
          pc_en     = 1'b1;
          reg2_en   = 1'b1;
          flush     = 1'b1;
          bus_err_d = 1'b1;
          state_d   = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      ST_FLUSH: begin
        pc_en   = 1'b1;
        reg2_en = 1'b1;
        flush   = 1'b1;
        state_d = redirect ? ST_FLUSH : ST_RUN;
      end
      default: begin
        flush   = 1'b1;
        state_d = ST_RUN;
      end
    endcase
  end

  // Reset overrides the combinational table so nothing moves while it is held.
  assign pc_en_out      = reset_in & pc_en;
  assign reg2_en_out    = reset_in & reg2_en;
  assign reg2_flush_out = reset_in & flush;
  assign state_out      = state_q;
  assign stall_cnt_out  = cnt_q;
  assign bus_err_out    = bus_err_q;

endmodule
